// File: rtl/pipo_usr.sv
// rtl/pipo_usr.sv - universal shift register with parallel load and multi-cycle shift/rotate
module pipo_usr #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] pin,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic             sin,
  output logic [WIDTH-1:0] pout,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SHL = 2'b00;
  localparam logic [1:0] OP_SHR = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             sout_q, sout_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pout_q  <= '0;
      sout_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      pout_q  <= pout_d;
      sout_q  <= sout_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pout_d  = pout_q;
    sout_d  = sout_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        // ld wins over start; a zero amount completes without any step
        if (ld) begin
          pout_d = pin;
        end else if (start) begin
          op_d    = op;
          cnt_d   = amt;
          state_d = (amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        case (op_q)
          OP_SHL: begin
            pout_d = {pout_q[WIDTH-2:0], sin};
            sout_d = pout_q[WIDTH-1];
          end
          OP_SHR: begin
            pout_d = {sin, pout_q[WIDTH-1:1]};
            sout_d = pout_q[0];
          end
          OP_ROL: begin
            pout_d = {pout_q[WIDTH-2:0], pout_q[WIDTH-1]};
            sout_d = pout_q[WIDTH-1];
          end
          default: begin
            pout_d = {pout_q[0], pout_q[WIDTH-1:1]};
            sout_d = pout_q[0];
          end
        endcase
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pout = pout_q;
  assign sout = sout_q;
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_pipo_usr.sv
// tb/tb_pipo_usr.sv - self-checking bench for pipo_usr against an arithmetic reference model
module tb_pipo_usr;
  localparam int W  = 4;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld;
  logic [W-1:0]  pin;
  logic          start;
  logic [1:0]    op;
  logic [AW-1:0] amt;
  logic          sin;
  logic [W-1:0]  pout;
  logic          sout;
  logic          busy;
  logic          done;

  int vectors = 0;
  int errors  = 0;

  logic [W-1:0] m_pout;
  logic         m_sout;

  pipo_usr #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .rst(rst), .ld(ld), .pin(pin), .start(start), .op(op),
    .amt(amt), .sin(sin), .pout(pout), .sout(sout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // one step as integer arithmetic: returns {sout, pout}
  function automatic logic [W:0] model_step(input logic [W-1:0] p, input logic [1:0] o, input logic s);
    int pi, r, so;
    pi = int'(p);
    case (o)
      2'd0: begin r = (pi << 1) | int'(s);        so = (pi >> (W-1)) & 1; end
      2'd1: begin r = (pi >> 1) | (int'(s) << (W-1)); so = pi & 1; end
      2'd2: begin r = (pi << 1) | (pi >> (W-1));  so = (pi >> (W-1)) & 1; end
      default: begin r = (pi >> 1) | ((pi & 1) << (W-1)); so = pi & 1; end
    endcase
    return {so[0], r[W-1:0]};
  endfunction

  task automatic do_load(input logic [W-1:0] v);
    ld = 1'b1; start = 1'b0; pin = v;
    @(negedge clk);
    ld = 1'b0;
    m_pout = v;
    vectors++;
    if (pout !== v || sout !== m_sout || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL load: pout=%b sout=%b busy=%b done=%b, want pout=%b sout=%b busy=0 done=0",
               pout, sout, busy, done, v, m_sout);
    end
  endtask

  task automatic do_op(input logic [1:0] o, input int n, input int sin_fix, input bit perturb, input string tag);
    logic [W:0]   r;
    logic [W-1:0] p0;
    logic         s;
    p0 = m_pout;
    ld = 1'b0; start = 1'b1; op = o; amt = n[AW-1:0];
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== (n != 0) || done !== (n == 0) || pout !== p0) begin
      errors++;
      $display("FAIL %s accept: busy=%b done=%b pout=%b, want busy=%b done=%b pout=%b",
               tag, busy, done, pout, (n != 0), (n == 0), p0);
    end
    for (int k = 1; k <= n; k++) begin
      s = (sin_fix < 0) ? 1'($urandom % 2) : sin_fix[0];
      sin = s;
      if (perturb) begin
        ld = 1'($urandom); start = 1'($urandom); pin = W'($urandom);
        op = 2'($urandom); amt = AW'($urandom);
      end
      @(negedge clk);
      r = model_step(m_pout, o, s);
      m_pout = r[W-1:0];
      m_sout = r[W];
      vectors++;
      if (pout !== m_pout || sout !== m_sout || busy !== (k < n) || done !== (k == n)) begin
        errors++;
        $display("FAIL %s step %0d: pout=%b sout=%b busy=%b done=%b, want pout=%b sout=%b busy=%b done=%b",
                 tag, k, pout, sout, busy, done, m_pout, m_sout, (k < n), (k == n));
      end
    end
    if (perturb) begin
      ld = 1'($urandom); start = 1'($urandom); pin = W'($urandom);
    end
    @(negedge clk);
    ld = 1'b0; start = 1'b0;
    vectors++;
    if (pout !== m_pout || sout !== m_sout || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s after done: pout=%b sout=%b busy=%b done=%b, want pout=%b sout=%b busy=0 done=0",
               tag, pout, sout, busy, done, m_pout, m_sout);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; ld = 1'b1; pin = 4'b1101; start = 1'b0; op = 2'b00; amt = '0; sin = 1'b0;
    m_pout = '0; m_sout = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (pout !== 4'b0000 || sout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: pout=%b sout=%b busy=%b done=%b, want 0000 0 0 0", pout, sout, busy, done);
    end
    rst = 1'b1;
    do_load(4'b1010);
  endtask

  task automatic test_hold();
    ld = 1'b0; pin = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (pout !== 4'b1010 || sout !== m_sout || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL hold %0d: pout=%b sout=%b, want pout=1010 sout=%b", i, pout, sout, m_sout);
      end
    end
  endtask

  task automatic test_shl();
    do_op(2'b00, 2, 1, 1'b0, "shl");
    vectors++;
    if (pout !== 4'b1011 || sout !== 1'b0) begin
      errors++;
      $display("FAIL shl final: pout=%b sout=%b, want 1011 0", pout, sout);
    end
  endtask

  task automatic test_ror();
    do_op(2'b11, 3, -1, 1'b1, "ror");
    vectors++;
    if (pout !== 4'b0111 || sout !== 1'b0) begin
      errors++;
      $display("FAIL ror final: pout=%b sout=%b, want 0111 0", pout, sout);
    end
  endtask

  task automatic test_zero_and_wrap();
    do_op(2'b01, 0, -1, 1'b1, "zero");
    do_load(4'b1001);
    do_op(2'b10, 4, -1, 1'b1, "rol_wrap");
    vectors++;
    if (pout !== 4'b1001) begin
      errors++;
      $display("FAIL rol_wrap final: pout=%b, want 1001", pout);
    end
  endtask

  task automatic test_random();
    logic [1:0]   o;
    int           n, rot, pi;
    logic [W-1:0] p0, want;
    for (int i = 0; i < 24; i++) begin
      if ($urandom % 2) do_load(W'($urandom));
      o  = 2'($urandom);
      n  = $urandom_range(0, (1 << AW) - 1);
      p0 = m_pout;
      do_op(o, n, -1, 1'b1, "random");
      if (o[1]) begin
        rot = n % W;
        pi  = int'(p0);
        if (o[0]) pi = (pi >> rot) | (pi << (W - rot));
        else      pi = (pi << rot) | (pi >> (W - rot));
        want = pi[W-1:0];
        vectors++;
        if (pout !== want) begin
          errors++;
          $display("FAIL random rotate op=%b amt=%0d from %b: pout=%b, want %b", o, n, p0, pout, want);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W:0] r;
    logic       s;
    do_load(4'b0110);
    ld = 1'b0; start = 1'b1; op = 2'b01; amt = AW'(5);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      s = 1'($urandom % 2);
      sin = s;
      @(negedge clk);
      r = model_step(m_pout, 2'b01, s);
      m_pout = r[W-1:0]; m_sout = r[W];
    end
    vectors++;
    if (pout !== m_pout || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid-op before reset: pout=%b busy=%b, want pout=%b busy=1", pout, busy, m_pout);
    end
    #1 rst = 1'b0;
    #1;
    m_pout = '0; m_sout = 1'b0;
    vectors++;
    if (pout !== 4'b0000 || sout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async reset: pout=%b sout=%b busy=%b done=%b, want 0000 0 0 0", pout, sout, busy, done);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || pout !== 4'b0000) begin
        errors++;
        $display("FAIL post-reset idle %0d: done=%b busy=%b pout=%b, want 0 0 0000", i, done, busy, pout);
      end
    end
    do_load(4'b1111);
    do_op(2'b00, 1, 0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    do_load(W'($urandom));
    do_op(2'b10, 2, -1, 1'b0, "b2b_a");
    do_op(2'b01, 3, -1, 1'b0, "b2b_b");
    do_op(2'b11, 0, -1, 1'b0, "b2b_c");
    do_op(2'b00, 7, -1, 1'b0, "b2b_d");
  endtask

  initial begin
    test_reset();
    test_hold();
    test_shl();
    test_ror();
    test_zero_and_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
